// File: rtl/ram_stream_reader_if.sv
// Bundle of the start/status, RAM read-port and output-stream signals of ram_stream_reader.
// The master modport is the reader itself; slave is the RAM/consumer side.
interface ram_stream_reader_if #(
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned MEM_DEPTH = 1024
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [AW:0]          length;
    logic                 busy;
    logic                 done;
    logic                 ram_enable;
    logic                 ram_write_en;
    logic                 ram_reset;
    logic [AW-1:0]        ram_address;
    logic [MEM_WIDTH-1:0] ram_data_out;
    logic                 m_valid;
    logic                 m_ready;
    logic [MEM_WIDTH-1:0] m_data;
    logic                 m_last;

    modport master (
        input  start, base_addr, length, ram_data_out, m_ready,
        output busy, done, ram_enable, ram_write_en, ram_reset, ram_address,
               m_valid, m_data, m_last
    );

    modport slave (
        output start, base_addr, length, ram_data_out, m_ready,
        input  busy, done, ram_enable, ram_write_en, ram_reset, ram_address,
               m_valid, m_data, m_last
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Sequential RAM reader: issues credit-limited reads and streams the returned words
// through a 2-entry FIFO onto a valid/ready port with a last marker.
module ram_stream_reader #(
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input logic                  clock,
    input logic                  reset_n,
    ram_stream_reader_if.master  io_bus
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] LastAddr = AW'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e               r_state;
    logic [AW:0]          r_len;
    logic [AW:0]          r_issued;
    logic [AW-1:0]        r_next_addr;
    logic [AW-1:0]        r_last_addr;
    logic                 r_pending;
    logic                 r_pending_last;
    logic                 r_busy;
    logic                 r_done;

    logic [1:0][MEM_WIDTH-1:0] r_fifo_data;
    logic [1:0]                r_fifo_last;
    logic                      r_wptr;
    logic                      r_rptr;
    logic [1:0]                r_count;

    logic          w_valid;
    logic          w_last;
    logic          w_pop;
    logic [2:0]    w_occ;
    logic          w_issue;
    logic          w_issue_last;
    logic [AW-1:0] w_addr_inc;

    assign w_valid = (r_count != 2'd0);
    assign w_last  = w_valid & r_fifo_last[r_rptr];
    assign w_pop   = w_valid & io_bus.m_ready;

    // Occupancy after this edge counting the read still in flight; never exceeds 2.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};
    assign w_issue = (r_state == StRun) && (r_issued < r_len) && (w_occ < 3'd2);

    assign w_issue_last = (r_issued == r_len - 1'b1);
    assign w_addr_inc   = (r_next_addr == LastAddr) ? '0 : r_next_addr + 1'b1;

    assign io_bus.busy         = r_busy;
    assign io_bus.done         = r_done;
    assign io_bus.ram_enable   = w_issue;
    assign io_bus.ram_write_en = 1'b0;
    assign io_bus.ram_reset    = 1'b0;
    assign io_bus.ram_address  = w_issue ? r_next_addr : r_last_addr;
    assign io_bus.m_valid      = w_valid;
    assign io_bus.m_data       = r_fifo_data[r_rptr];
    assign io_bus.m_last       = w_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= StIdle;
            r_len          <= '0;
            r_issued       <= '0;
            r_next_addr    <= '0;
            r_last_addr    <= '0;
            r_pending      <= 1'b0;
            r_pending_last <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done         <= 1'b0;
            r_pending      <= w_issue;
            r_pending_last <= w_issue & w_issue_last;
            unique case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        if (io_bus.length != '0) begin
                            r_len       <= io_bus.length;
                            r_issued    <= '0;
                            r_next_addr <= io_bus.base_addr;
                            r_busy      <= 1'b1;
                            r_state     <= StRun;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (w_issue) begin
                        r_issued    <= r_issued + 1'b1;
                        r_next_addr <= w_addr_inc;
                        r_last_addr <= r_next_addr;
                        if (w_issue_last) begin
                            r_state <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    if (w_pop && w_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Read data is captured the cycle after its issue edge; credits guarantee a free slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo_data <= '0;
            r_fifo_last <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (r_pending) begin
                r_fifo_data[r_wptr] <= io_bus.ram_data_out;
                r_fifo_last[r_wptr] <= r_pending_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, r_pending} - {1'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: directed transfers push expected words,
// a negedge monitor pops and compares on every stream handshake.
module tb_ram_stream_reader;
    localparam int unsigned W = 32;
    localparam int unsigned D = 1024;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    ram_stream_reader_if #(.MEM_WIDTH(W), .MEM_DEPTH(D)) bus ();

    ram_stream_reader #(.MEM_WIDTH(W), .MEM_DEPTH(D)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io_bus  (bus)
    );

    always #5 clock = ~clock;

    logic [31:0] ram [D];
    always @(posedge clock) begin
        if (bus.ram_enable) bus.ram_data_out <= ram[bus.ram_address];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    exp_t        exp_q[$];
    logic [9:0]  addr_q[$];
    int n_cmp = 0, n_bad = 0;
    int en_cnt = 0, hs_cnt = 0, done_cnt = 0, busy_cnt = 0, vld_cnt = 0, ov_cnt = 0;
    int rise_cyc = -1, last_hs_cyc = -1, done_cyc = -1;
    bit rand_ready = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    initial begin
        forever begin
            bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clock);
            #1;
        end
    end

    // Monitor: all stream observation happens mid-cycle, away from the rising edge.
    initial begin
        bit          prev_stall = 1'b0;
        bit          prev_valid = 1'b0;
        logic [31:0] prev_data  = '0;
        logic        prev_last  = 1'b0;
        int          outst      = 0;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
                outst      = 0;
            end else begin
                if (bus.ram_enable) begin
                    en_cnt++;
                    outst++;
                    addr_q.push_back(bus.ram_address);
                end
                if (bus.busy) busy_cnt++;
                if (bus.m_valid) vld_cnt++;
                if (bus.m_valid && !prev_valid) rise_cyc = cyc;
                if (prev_stall) begin
                    chk("hold_under_backpressure", 64'({bus.m_valid, bus.m_last, bus.m_data}),
                        64'({1'b1, prev_last, prev_data}));
                end
                if (bus.m_valid && bus.m_ready) begin
                    hs_cnt++;
                    outst--;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %h, required no word", bus.m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word{last,data}", 64'({bus.m_last, bus.m_data}),
                            64'({e.last, e.data}));
                    end
                    if (bus.m_last) last_hs_cyc = cyc;
                end
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (outst > 2) ov_cnt++;
                prev_valid = bus.m_valid;
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
                prev_last  = bus.m_last;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      64'(bus.busy), 64'd0);
        chk({tag, "_done"},      64'(bus.done), 64'd0);
        chk({tag, "_ram_en"},    64'(bus.ram_enable), 64'd0);
        chk({tag, "_ram_addr"},  64'(bus.ram_address), 64'd0);
        chk({tag, "_m_valid"},   64'(bus.m_valid), 64'd0);
        chk({tag, "_m_last"},    64'(bus.m_last), 64'd0);
        chk({tag, "_m_data"},    64'(bus.m_data), 64'd0);
        chk({tag, "_wr_rst"},    64'({bus.ram_write_en, bus.ram_reset}), 64'd0);
    endtask

    task automatic xfer(input int base, input int len, input bit chk_timing, input bit ghost);
        int e0, en0, dn0, bz0, vl0, ov0, t;
        @(posedge clock);
        #1;
        en0 = en_cnt; dn0 = done_cnt; bz0 = busy_cnt; vl0 = vld_cnt; ov0 = ov_cnt;
        bus.start     = 1'b1;
        bus.base_addr = 10'(base);
        bus.length    = 11'(len);
        e0 = cyc + 1;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{data: ram[(base + i) % D], last: (i == len - 1)});
        end
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        if (ghost) begin
            repeat (3) @(posedge clock);
            #1;
            bus.start = 1'b1; bus.base_addr = 10'd5; bus.length = 11'd3;
            @(posedge clock);
            #1;
            bus.start = 1'b0;
        end
        t = 0;
        while (done_cnt == dn0 && t < 1000) begin
            @(posedge clock);
            t++;
        end
        if (done_cnt == dn0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done in %0d cycles, required a done pulse", t);
        end
        repeat (3) @(posedge clock);
        #1;
        chk("done_pulse_count", 64'(done_cnt - dn0), 64'd1);
        chk("enable_cycles", 64'(en_cnt - en0), 64'(len));
        chk("words_left", 64'(exp_q.size()), 64'd0);
        chk("fifo_over_2", 64'(ov_cnt - ov0), 64'd0);
        if (len > 0) begin
            chk("done_after_last", 64'(done_cyc), 64'(last_hs_cyc + 1));
        end else begin
            chk("len0_done_cycle", 64'(done_cyc), 64'(e0));
            chk("len0_busy", 64'(busy_cnt - bz0), 64'd0);
            chk("len0_valid", 64'(vld_cnt - vl0), 64'd0);
        end
        if (chk_timing) begin
            chk("first_valid_cycle", 64'(rise_cyc), 64'(e0 + 2));
            chk("back_to_back", 64'(last_hs_cyc - rise_cyc), 64'(len - 1));
        end
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] tab [12];
        int a0, hs0, dn0, t;
        tab = '{32'h3e96bb98, 32'h3e34bc6a, 32'h3dc1f212, 32'h3f020c49,
                32'h3e820c49, 32'h3e020c49, 32'h3c1ba5e3, 32'h3ad1b717,
                32'h3951b717, 32'h3ba3d70a, 32'h00000000, 32'h3a51b717};
        for (int i = 0; i < int'(D); i++) ram[i] = 32'ha500_0000 | 32'(i);
        for (int i = 0; i < 12; i++) ram[i] = tab[i];
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.length = '0;

        #12;
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        xfer(0, 12, 1'b1, 1'b0);

        rand_ready = 1'b1;
        xfer(0, 12, 1'b0, 1'b0);
        rand_ready = 1'b0;
        repeat (2) @(posedge clock);

        a0 = addr_q.size();
        xfer(1022, 4, 1'b1, 1'b0);
        chk("wrap_addr_count", 64'(addr_q.size() - a0), 64'd4);
        if (addr_q.size() - a0 == 4) begin
            chk("wrap_addr0", 64'(addr_q[a0]),     64'd1022);
            chk("wrap_addr1", 64'(addr_q[a0 + 1]), 64'd1023);
            chk("wrap_addr2", 64'(addr_q[a0 + 2]), 64'd0);
            chk("wrap_addr3", 64'(addr_q[a0 + 3]), 64'd1);
        end

        xfer(0, 0, 1'b0, 1'b0);

        xfer(0, 12, 1'b1, 1'b1);

        // Abort after 5 words with an asynchronous reset placed between clock edges.
        @(posedge clock);
        #1;
        hs0 = hs_cnt;
        dn0 = done_cnt;
        bus.start = 1'b1; bus.base_addr = 10'd0; bus.length = 11'd12;
        for (int i = 0; i < 12; i++) exp_q.push_back('{data: tab[i], last: (i == 11)});
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        t = 0;
        while (hs_cnt - hs0 < 5 && t < 200) begin
            @(posedge clock);
            #1;
            t++;
        end
        chk("words_before_abort", 64'(hs_cnt - hs0), 64'd5);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("abort_no_done", 64'(done_cnt - dn0), 64'd0);

        xfer(3, 2, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
